// File: rtl/eim_bus_initiator.sv
// Initiator for the CS5 asynchronous register bus: turns one valid/ready request
// into a full address/strobe/hold bus cycle and reports completion with rsp_valid.
module eim_bus_initiator #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 6,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [23:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [23:0] bus_addr,
  output logic [3:0]  bus_be_b,
  output logic        bus_as,
  output logic        bus_rs_b,
  output logic        bus_ws_b,
  output logic [31:0] bus_dout,
  output logic        bus_doe,
  input  logic [31:0] bus_din
);

  // Zero-length phases are treated as one cycle so the counter never underflows.
  localparam int SETUP_EFF  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
  localparam int STROBE_EFF = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
  localparam int HOLD_EFF   = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;
  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_EFF - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_EFF - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [23:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_b_q, bus_be_b_d;
  logic        bus_as_q, bus_as_d;
  logic        bus_rs_b_q, bus_rs_b_d;
  logic        bus_ws_b_q, bus_ws_b_d;
  logic [31:0] bus_dout_q, bus_dout_d;
  logic        bus_doe_q, bus_doe_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_be_b_d  = bus_be_b_q;
    bus_as_d    = bus_as_q;
    bus_rs_b_d  = bus_rs_b_q;
    bus_ws_b_d  = bus_ws_b_q;
    bus_dout_d  = bus_dout_q;
    bus_doe_d   = bus_doe_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d     = SETUP;
          cnt_d       = SETUP_LOAD;
          rw_d        = req_rw;
          req_ready_d = 1'b0;
          bus_addr_d  = req_addr;
          bus_be_b_d  = ~req_be;
          bus_as_d    = 1'b1;
          if (!req_rw) begin
            bus_dout_d  = req_wdata;
            bus_doe_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d    = STROBE;
          cnt_d      = STROBE_LOAD;
          bus_rs_b_d = ~rw_q;
          bus_ws_b_d = rw_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d    = HOLD;
          cnt_d      = HOLD_LOAD;
          bus_rs_b_d = 1'b1;
          bus_ws_b_d = 1'b1;
          // Read data is sampled on the same edge that releases the strobe.
          if (rw_q) begin
            rsp_rdata_d = bus_din;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          bus_as_d    = 1'b0;
          bus_be_b_d  = 4'hF;
          bus_doe_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = ~req_ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      rw_q        <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      bus_addr_q  <= 24'h0;
      bus_be_b_q  <= 4'hF;
      bus_as_q    <= 1'b0;
      bus_rs_b_q  <= 1'b1;
      bus_ws_b_q  <= 1'b1;
      bus_dout_q  <= 32'h0;
      bus_doe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_b_q  <= bus_be_b_d;
      bus_as_q    <= bus_as_d;
      bus_rs_b_q  <= bus_rs_b_d;
      bus_ws_b_q  <= bus_ws_b_d;
      bus_dout_q  <= bus_dout_d;
      bus_doe_q   <= bus_doe_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be_b  = bus_be_b_q;
  assign bus_as    = bus_as_q;
  assign bus_rs_b  = bus_rs_b_q;
  assign bus_ws_b  = bus_ws_b_q;
  assign bus_dout  = bus_dout_q;
  assign bus_doe   = bus_doe_q;

endmodule
